seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for N common-anode 7-segment digits sharing one SEG bus.

---
 rtl/seg7_if.sv | 23 ++
 rtl/seg7_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Bus between the display datapath (master) and the 7-segment scan driver (slave).
// Signal suffixes are from the driver's point of view.
interface seg7_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value_i;
    logic [N_DIGITS-1:0]   dp_i;
    logic                  load_i;
    logic                  blank_lz_i;
    logic [7:0]            seg_o;
    logic [N_DIGITS-1:0]   an_o;
    logic                  frame_o;

    modport master (
        output value_i, dp_i, load_i, blank_lz_i,
        input  seg_o, an_o, frame_o
    );

    modport slave (
        input  value_i, dp_i, load_i, blank_lz_i,
        output seg_o, an_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver with frame-consistent shadowing, leading-zero blanking
// and a blank slot between digits. Define SEG7_HEX_EN to show codes 10..15 as A,b,C,d,E,F.
module seg7_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int ACTIVE_LOW = 1
) (
    input logic   clk,
    input logic   rst,
    seg7_if.slave bus
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]      div_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  show_q;
    logic                  frame_q;
    logic                  pending_q;
    logic [4*N_DIGITS-1:0] stage_q;
    logic [N_DIGITS-1:0]   stage_dp_q;
    logic [4*N_DIGITS-1:0] shadow_q;
    logic [N_DIGITS-1:0]   shadow_dp_q;
    logic [7:0]            seg_q;
    logic [N_DIGITS-1:0]   an_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  lz_blank;
    logic [7:0]            seg_d;
    logic [N_DIGITS-1:0]   an_d;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
`ifdef SEG7_HEX_EN
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
`else
            default: g = 7'h00;
`endif
        endcase
        return g;
    endfunction

    assign tick = (div_q == DIV_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);
    assign nib  = shadow_q[4*idx_q +: 4];

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = bus.blank_lz_i && (idx_q != '0);
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((k >= int'(idx_q)) && (shadow_q[4*k +: 4] != 4'h0)) lz_blank = 1'b0;
        end
    end

    always_comb begin
        seg_d = {shadow_dp_q[idx_q], lz_blank ? 7'h00 : glyph(nib)};
        an_d  = N_DIGITS'(1) << idx_q;
        if (ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            show_q      <= 1'b0;
            frame_q     <= 1'b0;
            pending_q   <= 1'b0;
            stage_q     <= '0;
            stage_dp_q  <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            div_q   <= tick ? '0 : div_q + 1'b1;
            show_q  <= tick;
            frame_q <= wrap;
            if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;

            // The cycle after a tick is the anti-ghost blank; the digit appears on the next one.
            if (tick) begin
                seg_q <= SEG_OFF;
                an_q  <= AN_OFF;
            end else if (show_q) begin
                seg_q <= seg_d;
                an_q  <= an_d;
            end

            if (bus.load_i) begin
                stage_q    <= bus.value_i;
                stage_dp_q <= bus.dp_i;
            end

            // A load coinciding with the wrap bypasses staging so it commits at this wrap.
            if (wrap) begin
                pending_q <= 1'b0;
                if (bus.load_i) begin
                    shadow_q    <= bus.value_i;
                    shadow_dp_q <= bus.dp_i;
                end else if (pending_q) begin
                    shadow_q    <= stage_q;
                    shadow_dp_q <= stage_dp_q;
                end
            end else if (bus.load_i) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: N=4, DIV=4, active-low outputs.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef SEG7_HEX_EN
    localparam logic [7:0] HEX_A = 8'h88;
`else
    localparam logic [7:0] HEX_A = 8'hFF;
`endif

    always #5 clk = ~clk;

    seg7_if #(.N_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .N_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(250), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_start();
        int n;
        rst = 1'b1;
        @(negedge clk);
        check("rst_seg", bus.seg_o, 8'hFF);
        check("rst_an", bus.an_o, 4'hF);
        check("rst_frame", bus.frame_o, 1'b0);
        rst = 1'b0;
        n = 0;
        while (bus.an_o === 4'hF && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_digit_latency", n, 5);
        check("first_digit_an", bus.an_o, 4'b1101);
        check("first_digit_seg", bus.seg_o, 8'hC0);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_o !== 1'b1 && n < 40);
        check("frame_seen", bus.frame_o, 1'b1);
    endtask

    // Starts on the negedge where frame is high and ends on the next such negedge.
    task automatic scan_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] an_exp;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            check({tag, "_blank_seg"}, bus.seg_o, 8'hFF);
            check({tag, "_blank_an"}, bus.an_o, 4'hF);
            @(negedge clk);
            bus.load_i = 1'b0;
            an_exp = ~(4'b0001 << k);
            check({tag, "_an"}, bus.an_o, an_exp);
            check({tag, "_seg"}, bus.seg_o, e[k]);
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        int frames;
        bus.value_i    = '0;
        bus.dp_i       = '0;
        bus.load_i     = 1'b0;
        bus.blank_lz_i = 1'b0;

        reset_start();

        frames = 0;
        repeat (64) begin
            @(negedge clk);
            if (bus.frame_o === 1'b1) frames++;
        end
        check("frame_rate", frames, 4);

        wait_frame();
        bus.value_i = 16'h1234; bus.load_i = 1'b1;
        scan_frame("hold_old", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        scan_frame("show_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        bus.value_i = 16'h0007; bus.load_i = 1'b1; bus.blank_lz_i = 1'b1;
        scan_frame("pre_0007", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        scan_frame("lz_0007", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        bus.blank_lz_i = 1'b0;
        scan_frame("nolz_0007", 8'hF8, 8'hC0, 8'hC0, 8'hC0);

        bus.value_i = 16'h0012; bus.dp_i = 4'b0100; bus.load_i = 1'b1; bus.blank_lz_i = 1'b1;
        scan_frame("pre_0012", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        scan_frame("dp_0012", 8'hA4, 8'hF9, 8'h7F, 8'hFF);

        bus.value_i = 16'h0A00; bus.dp_i = 4'b0000; bus.load_i = 1'b1;
        scan_frame("pre_0A00", 8'hA4, 8'hF9, 8'h7F, 8'hFF);
        scan_frame("hex_0A00", 8'hC0, 8'hC0, HEX_A, 8'hFF);

        bus.value_i = 16'h1111; bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.value_i = 16'h2222; bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        wait_frame();
        scan_frame("last_load", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        @(negedge clk);
        bus.value_i = 16'h5555; bus.load_i = 1'b1;
        @(posedge clk);
        #2;
        bus.load_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_seg", bus.seg_o, 8'hFF);
        check("midrst_an", bus.an_o, 4'hF);
        check("midrst_frame", bus.frame_o, 1'b0);
        bus.blank_lz_i = 1'b0;
        reset_start();
        wait_frame();
        scan_frame("pending_lost", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
